// File: rtl/systolic_pkg.sv
// Shared types and pixel normalisation for the brightness systolic array.
package systolic_pkg;

  localparam int unsigned NumCols      = 4;
  localparam int unsigned AccWidth     = 24;
  localparam int unsigned PixWidth     = 8;
  localparam int unsigned AccShift     = 4;
  localparam int unsigned RowFifoDepth = 4;

  typedef logic [AccWidth-1:0] acc_t;
  typedef logic [PixWidth-1:0] pix_t;
  typedef pix_t [NumCols-1:0]  row_t;

  typedef enum logic [0:0] {StIdle, StCapt} cap_state_e;

  // Round-half-up, shift, then saturate; the extra sum bit keeps large accumulators from wrapping.
  function automatic pix_t sat_shift(acc_t acc, int unsigned shift);
    logic [AccWidth:0] rnd;
    logic [AccWidth:0] sum;
    pix_t              res;
    rnd = (shift > 0) ? ((AccWidth+1)'(1) << (shift - 1)) : '0;
    sum = ({1'b0, acc} + rnd) >> shift;
    res = (|sum[AccWidth:PixWidth]) ? '1 : sum[PixWidth-1:0];
    return res;
  endfunction

endpackage

// File: rtl/drain_row_fifo.sv
// Row FIFO between the capture FSM and the pixel serializer.
module drain_row_fifo
  import systolic_pkg::*;
#(
  parameter int unsigned Depth = RowFifoDepth
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  row_t                   push_row_i,
  input  logic                   pop_i,
  output row_t                   head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  row_t        mem_q [Depth];
  logic        do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (count_o == (AW+1)'(Depth));
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= push_row_i;
  end

endmodule

// File: rtl/systolic_drain.sv
// Captures skewed column results into rows, buffers them, and streams pixels out.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int unsigned COLS       = NumCols,
  parameter int unsigned ACC_WIDTH  = AccWidth,
  parameter int unsigned PIX_WIDTH  = PixWidth,
  parameter int unsigned SHIFT      = AccShift,
  parameter int unsigned FIFO_DEPTH = RowFifoDepth
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          capture_start,
  input  logic [COLS*ACC_WIDTH-1:0]     acc_in,
  output logic [PIX_WIDTH-1:0]          pix_out,
  output logic                          pix_valid,
  output logic                          pix_last,
  input  logic                          pix_ready,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned ColW = $clog2(COLS);

  cap_state_e      state_q, state_d;
  logic [ColW-1:0] col_idx_q, col_idx_d;
  logic [ColW-1:0] out_idx_q, out_idx_d;
  row_t            row_q, row_d, push_row, head_row;
  logic            ovf_q, ovf_d;
  logic            push, pop, full, empty, start_err, drop, hs, col_last, out_last;
  acc_t            col_acc, acc0;

  assign col_acc  = acc_in[col_idx_q*ACC_WIDTH +: ACC_WIDTH];
  assign acc0     = acc_in[ACC_WIDTH-1:0];
  assign col_last = (col_idx_q == ColW'(COLS - 1));

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_d     = row_q;
    push_row  = row_q;
    push      = 1'b0;
    start_err = 1'b0;
    case (state_q)
      StIdle: begin
        if (capture_start) begin
          row_d[0]  = sat_shift(acc0, SHIFT);
          col_idx_d = ColW'(1);
          state_d   = StCapt;
        end
      end
      StCapt: begin
        push_row[col_idx_q] = sat_shift(col_acc, SHIFT);
        row_d               = push_row;
        if (col_last) begin
          push = 1'b1;
          // A start on the closing edge chains straight into the next row.
          if (capture_start) begin
            row_d[0]  = sat_shift(acc0, SHIFT);
            col_idx_d = ColW'(1);
          end else begin
            col_idx_d = '0;
            state_d   = StIdle;
          end
        end else begin
          col_idx_d = col_idx_q + ColW'(1);
          start_err = capture_start;
        end
      end
      default: state_d = StIdle;
    endcase
    if (clear) begin
      state_d   = StIdle;
      col_idx_d = '0;
      push      = 1'b0;
    end
  end

  assign pix_valid = !empty;
  assign out_last  = (out_idx_q == ColW'(COLS - 1));
  assign pix_out   = pix_valid ? head_row[out_idx_q] : '0;
  assign pix_last  = pix_valid && out_last;
  assign hs        = pix_valid && pix_ready;
  assign pop       = hs && out_last;
  assign drop      = push && full && !pop;
  assign busy      = (state_q == StCapt);
  assign overflow  = ovf_q;

  always_comb begin
    out_idx_d = out_idx_q;
    if (hs) out_idx_d = out_last ? '0 : out_idx_q + ColW'(1);
    if (clear) out_idx_d = '0;
    ovf_d = clear ? 1'b0 : (ovf_q | start_err | drop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      col_idx_q <= '0;
      out_idx_q <= '0;
      row_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      out_idx_q <= out_idx_d;
      row_q     <= row_d;
      ovf_q     <= ovf_d;
    end
  end

  drain_row_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .clear_i   (clear),
    .push_i    (push),
    .push_row_i(push_row),
    .pop_i     (pop),
    .head_o    (head_row),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (fifo_count)
  );

endmodule

// File: tb/tb_systolic_drain.sv
// Directed self-checking bench for systolic_drain (COLS=4, SHIFT=4, FIFO_DEPTH=4).
module tb_systolic_drain;

  localparam int C  = 4;
  localparam int AW = 24;

  logic            clk, reset, clear, capture_start, pix_ready;
  logic [C*AW-1:0] acc_in;
  logic [7:0]      pix_out;
  logic            pix_valid, pix_last, busy, overflow;
  logic [2:0]      fifo_count;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int cyc = 0, busy_gaps = 0, nrows = 0;
  logic [AW-1:0] rowv [8][C];
  int            row_start [8];
  logic [7:0]    pq [$];
  logic          lq [$];
  int            cq [$];

  systolic_drain dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .capture_start(capture_start),
    .acc_in       (acc_in),
    .pix_out      (pix_out),
    .pix_valid    (pix_valid),
    .pix_last     (pix_last),
    .pix_ready    (pix_ready),
    .busy         (busy),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 1 time unit after posedge, so negedge sees the upcoming handshake.
  always @(negedge clk) begin
    if (pix_valid && pix_ready) begin
      pq.push_back(pix_out);
      lq.push_back(pix_last);
      cq.push_back(cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    pq.delete();
    lq.delete();
    cq.delete();
  endtask

  task automatic run_sched(input int cycles, input int rlo, input int rhi);
    for (int t = 0; t < cycles; t++) begin
      acc_in        = '1;
      capture_start = 1'b0;
      pix_ready     = (t >= rlo) && (t < rhi);
      for (int i = 0; i < nrows; i++) begin
        int k;
        k = t - row_start[i];
        if (k >= 0 && k < C) begin
          acc_in[k*AW +: AW] = rowv[i][k];
          if (k == 0) capture_start = 1'b1;
        end
      end
      step();
      if (t < cycles - 1 && !busy) busy_gaps++;
    end
    capture_start = 1'b0;
    acc_in        = '1;
  endtask

  task automatic wait_pix(input int n, input int budget);
    int b;
    b = 0;
    while (pq.size() < n && b < budget) begin
      step();
      b++;
    end
  endtask

  task automatic chk_pix(input string tag, input int j, input logic [7:0] e);
    if (j < pq.size()) begin
      chk($sformatf("%s_pix%0d", tag, j), {24'd0, pq[j]}, {24'd0, e});
      chk($sformatf("%s_last%0d", tag, j), {31'd0, lq[j]}, {31'd0, (j % C) == C - 1});
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, pix_valid}, 0);
    chk({tag, "_out"}, {24'd0, pix_out}, 0);
    chk({tag, "_last"}, {31'd0, pix_last}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_count"}, {29'd0, fifo_count}, 0);
  endtask

  logic [7:0] exp2 [3][C];

  initial begin
    reset = 1'b0; clear = 1'b0; capture_start = 1'b0; pix_ready = 1'b0; acc_in = '1;
    exp2[0] = '{8'h01, 8'h02, 8'hFF, 8'h09};
    exp2[1] = '{8'h0A, 8'h7F, 8'h80, 8'hFE};
    exp2[2] = '{8'h00, 8'h00, 8'h01, 8'hFF};
    #3;
    chk_idle("rst");
    chk("rst_ovf", {31'd0, overflow}, 0);
    @(posedge clk); #1; reset = 1'b1;
    step();

    // Normalise and saturate, with first-pixel latency.
    pix_ready = 1'b1;
    acc_in = '1; acc_in[0*AW +: AW] = 24'h000100; capture_start = 1'b1; step();
    chk("t1_busy", {31'd0, busy}, 1);
    chk("t1_v0", {31'd0, pix_valid}, 0);
    capture_start = 1'b0;
    acc_in = '1; acc_in[1*AW +: AW] = 24'h0000F7; step();
    chk("t1_v1", {31'd0, pix_valid}, 0);
    acc_in = '1; acc_in[2*AW +: AW] = 24'h000FF8; step();
    chk("t1_v2", {31'd0, pix_valid}, 0);
    acc_in = '1; acc_in[3*AW +: AW] = 24'h000000; step();
    acc_in = '1;
    chk("t1_v3", {31'd0, pix_valid}, 1);
    chk("t1_p0", {24'd0, pix_out}, 32'h10);
    chk("t1_l0", {31'd0, pix_last}, 0);
    chk("t1_cnt", {29'd0, fifo_count}, 1);
    chk("t1_busy_end", {31'd0, busy}, 0);
    step(); chk("t1_p1", {24'd0, pix_out}, 32'h0F);
    step(); chk("t1_p2", {24'd0, pix_out}, 32'hFF);
    step(); chk("t1_p3", {24'd0, pix_out}, 32'h00);
    chk("t1_l3", {31'd0, pix_last}, 1);
    step();
    chk("t1_drained", {31'd0, pix_valid}, 0);
    chk("t1_ovf", {31'd0, overflow}, 0);

    // Back-to-back rows chained on the closing edge.
    clear_q();
    rowv[0] = '{24'h000010, 24'h000020, 24'h00FFFF, 24'h000088};
    rowv[1] = '{24'h0000A0, 24'h0007F7, 24'h0007F8, 24'h000FE7};
    rowv[2] = '{24'h000000, 24'h000007, 24'h000008, 24'hFFFFFF};
    row_start[0] = 0; row_start[1] = 3; row_start[2] = 6; nrows = 3;
    busy_gaps = 0;
    run_sched(10, 0, 1000);
    chk("t2_busy_gaps", busy_gaps, 0);
    pix_ready = 1'b1;
    wait_pix(12, 40);
    step(); step(); step();
    chk("t2_npix", pq.size(), 12);
    for (int j = 0; j < 12; j++) chk_pix("t2", j, exp2[j / C][j % C]);
    if (pq.size() == 12) chk("t2_contig", cq[11] - cq[0], 11);
    chk("t2_ovf", {31'd0, overflow}, 0);

    // Backpressure: five rows into a four-deep FIFO.
    clear_q();
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < C; c++) rowv[i][c] = AW'((i * 16 + c) << 4);
      row_start[i] = 4 * i;
    end
    nrows = 5;
    run_sched(20, 0, 0);
    chk("t3_cnt", {29'd0, fifo_count}, 4);
    chk("t3_ovf", {31'd0, overflow}, 1);
    chk("t3_valid", {31'd0, pix_valid}, 1);
    chk("t3_hold0", {24'd0, pix_out}, 32'h00);
    step();
    chk("t3_hold1", {24'd0, pix_out}, 32'h00);
    chk("t3_hold_v", {31'd0, pix_valid}, 1);
    pix_ready = 1'b1;
    wait_pix(16, 40);
    step(); step(); step();
    chk("t3_npix", pq.size(), 16);
    for (int j = 0; j < 16; j++) chk_pix("t3", j, 8'((j / C) * 16 + (j % C)));
    chk("t3_cnt_end", {29'd0, fifo_count}, 0);

    // Full FIFO with the head's last pixel leaving on the push edge.
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_ovf", {31'd0, overflow}, 0);
    chk("clr_cnt", {29'd0, fifo_count}, 0);
    clear_q();
    run_sched(20, 16, 20);
    pix_ready = 1'b0;
    chk("t4_cnt", {29'd0, fifo_count}, 4);
    chk("t4_ovf", {31'd0, overflow}, 0);
    chk("t4_npop", pq.size(), 4);
    pix_ready = 1'b1;
    wait_pix(20, 40);
    step(); step();
    chk("t4_npix", pq.size(), 20);
    for (int j = 0; j < 20; j++) chk_pix("t4", j, 8'((j / C) * 16 + (j % C)));

    // Start two cycles into a capture is ignored.
    clear_q();
    rowv[0] = '{24'h0000A0, 24'h0007F7, 24'h0007F8, 24'h000FE7};
    rowv[1] = '{24'h000100, 24'h000100, 24'h000100, 24'h000100};
    row_start[0] = 0; row_start[1] = 2; nrows = 2;
    run_sched(6, 0, 100);
    wait_pix(4, 20);
    step(); step(); step(); step();
    chk("t5_npix", pq.size(), 4);
    for (int j = 0; j < 4; j++) chk_pix("t5", j, exp2[1][j]);
    chk("t5_ovf", {31'd0, overflow}, 1);

    // Reset during column 2 of a capture.
    clear_q();
    rowv[0] = '{24'h000010, 24'h000020, 24'h00FFFF, 24'h000088};
    row_start[0] = 0; nrows = 1;
    run_sched(2, 0, 0);
    acc_in = '1; acc_in[2*AW +: AW] = rowv[0][2];
    #1 reset = 1'b0;
    #1;
    chk_idle("r1");
    chk("r1_ovf", {31'd0, overflow}, 0);
    step(); reset = 1'b1;
    acc_in = '1; acc_in[3*AW +: AW] = rowv[0][3];
    pix_ready = 1'b1;
    step(); acc_in = '1;
    for (int i = 0; i < 6; i++) step();
    chk("r1_noemit", pq.size(), 0);
    chk("r1_valid", {31'd0, pix_valid}, 0);

    // Reset while pixel 1 of a row is pending.
    run_sched(4, 0, 0);
    pix_ready = 1'b1; step(); pix_ready = 1'b0;
    chk("r2_pix1", {24'd0, pix_out}, 32'h02);
    #1 reset = 1'b0;
    #1;
    chk_idle("r2");
    step(); reset = 1'b1;
    pix_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("r2_noemit", pq.size(), 1);
    clear_q();
    run_sched(4, 0, 100);
    wait_pix(4, 20);
    step(); step();
    chk("r3_npix", pq.size(), 4);
    for (int j = 0; j < 4; j++) chk_pix("r3", j, exp2[0][j]);

    // Clear during column 2, with overflow raised by a misaligned start.
    clear_q();
    rowv[1] = rowv[0];
    row_start[0] = 0; row_start[1] = 1; nrows = 2;
    run_sched(2, 0, 0);
    chk("c1_ovf_set", {31'd0, overflow}, 1);
    acc_in = '1; acc_in[2*AW +: AW] = rowv[0][2];
    clear = 1'b1; step(); clear = 1'b0;
    chk_idle("c1");
    chk("c1_ovf", {31'd0, overflow}, 0);
    acc_in = '1; acc_in[3*AW +: AW] = rowv[0][3];
    pix_ready = 1'b1;
    step(); acc_in = '1;
    for (int i = 0; i < 6; i++) step();
    chk("c1_noemit", pq.size(), 0);

    // Clear while pixel 1 of a row is pending.
    nrows = 1;
    run_sched(4, 0, 0);
    pix_ready = 1'b1; step(); pix_ready = 1'b0;
    chk("c2_pix1", {24'd0, pix_out}, 32'h02);
    clear = 1'b1; step(); clear = 1'b0;
    chk_idle("c2");
    pix_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("c2_noemit", pq.size(), 1);
    clear_q();
    rowv[0] = '{24'h000000, 24'h000007, 24'h000008, 24'hFFFFFF};
    run_sched(4, 0, 100);
    wait_pix(4, 20);
    step(); step();
    chk("c3_npix", pq.size(), 4);
    for (int j = 0; j < 4; j++) chk_pix("c3", j, exp2[2][j]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
